ram2_write_controller: RTL

RAM2_WRITE_CONTROLLER -- requirements
Module: ram2_write_controller

---
 rtl/ram2_write_controller.sv | 125 ++++++++++++
 1 files changed

// File: rtl/ram2_write_controller.sv
// Writes one output feature map into RAM2 in channel-planar order from a channel-innermost stream.
// Each accepted word produces one write one cycle later; iVALID is never stalled, so there is no backpressure.
module ram2_write_controller #(
    parameter int DW  = 16,
    parameter int AW  = 15,
    parameter int OW  = 11,
    parameter int OH  = 15,
    parameter int NCH = 112
) (
    input  logic          iCLK,
    input  logic          iRSTn,
    input  logic          iCLR,
    input  logic          iEN,
    input  logic          iVALID,
    input  logic [DW-1:0] iDATA,
    output logic [AW-1:0] oWr_ADDR,
    output logic [DW-1:0] oWr_DATA,
    output logic          oWr_EN,
    output logic          oWr_DONE,
    output logic          oBUSY,
    output logic          oERR
);

    localparam int            PLANE     = OW * OH;
    localparam logic [AW-1:0] PLANE_A   = AW'(PLANE);
    localparam logic [AW-1:0] LAST_BASE = AW'((NCH - 1) * PLANE);
    localparam logic [AW-1:0] LAST_PIX  = AW'(PLANE - 1);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] ch_base_q, ch_base_d;
    logic [AW-1:0] pix_q, pix_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [DW-1:0] wr_data_q, wr_data_d;
    logic          wr_en_q, wr_en_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;

    always_comb begin
        state_d   = state_q;
        ch_base_d = ch_base_q;
        pix_d     = pix_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_en_d   = 1'b0;
        err_d     = err_q;

        if (iCLR) begin
            state_d   = S_IDLE;
            ch_base_d = '0;
            pix_d     = '0;
            wr_addr_d = '0;
            wr_data_d = '0;
            err_d     = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // A word arriving with the start strobe still belongs to no frame.
                    if (iVALID) err_d = 1'b1;
                    if (iEN) state_d = S_WRITE;
                end
                S_WRITE: begin
                    if (iVALID) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = ch_base_q + pix_q;
                        wr_data_d = iDATA;
                        if (ch_base_q == LAST_BASE) begin
                            ch_base_d = '0;
                            if (pix_q == LAST_PIX) begin
                                pix_d   = '0;
                                state_d = S_DONE;
                            end else begin
                                pix_d = pix_q + 1'b1;
                            end
                        end else begin
                            ch_base_d = ch_base_q + PLANE_A;
                        end
                    end
                end
                S_DONE: begin
                    if (iVALID) err_d = 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Status flags track the next state so DONE rises with the final write pulse.
        busy_d = (state_d == S_WRITE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            state_q   <= S_IDLE;
            ch_base_q <= '0;
            pix_q     <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ch_base_q <= ch_base_d;
            pix_q     <= pix_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    assign oWr_ADDR = wr_addr_q;
    assign oWr_DATA = wr_data_q;
    assign oWr_EN   = wr_en_q;
    assign oWr_DONE = done_q;
    assign oBUSY    = busy_q;
    assign oERR     = err_q;

endmodule
